// File: rtl/pa_lsu_spsram_ctrl_define.sv
// Shared encodings and default sizing for the LSU single-port SRAM controller.
package pa_lsu_spsram_ctrl_define;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned ADDR_WIDTH_DEF   = 8;
    localparam int unsigned DATA_WIDTH_DEF   = 4;
    localparam logic [3:0]  INIT_VAL_DEF     = 4'b0000;
    localparam int unsigned STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/pa_lsu_spsram_sweep.sv
// Address sweeper for the init/flush clear: one entry per enabled cycle, pulses done on the last.
module pa_lsu_spsram_sweep #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = LAST_ADDR - ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] cnt;

    // done is registered one entry early so it lines up with the last write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (start) begin
                cnt <= '0;
            end else if (enable) begin
                cnt <= cnt + ADDR_WIDTH'(1);
            end
            done <= enable && (cnt == PRE_LAST);
        end
    end

    assign addr = cnt;
    assign last = enable && (cnt == LAST_ADDR);
    assign busy = enable;

endmodule

// File: rtl/pa_lsu_spsram_ctrl.sv
// Sweep sequencer and write-priority arbiter for one LSU single-port SRAM.
// Optional same-address read bypass: define PA_LSU_SPSRAM_CTRL_RD_BYPASS_EN.
module pa_lsu_spsram_ctrl
    import pa_lsu_spsram_ctrl_define::*;
#(
    parameter int unsigned           ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned           DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL     = DATA_WIDTH'(INIT_VAL_DEF),
    parameter int unsigned           STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  init_done,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_rdata_vld,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  wr_vld,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [SW-1:0]         starve_cnt;
    logic                  starve_hit;
    logic                  sweep_start, sweep_en, sweep_last;
    logic [ADDR_WIDTH-1:0] sweep_addr;
`ifdef PA_LSU_SPSRAM_CTRL_RD_BYPASS_EN
    logic                  byp;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
`endif

    assign starve_hit = (starve_cnt == STARVE_MAX);

    pa_lsu_spsram_sweep #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep (
        .clk    (forever_cpuclk),
        .rst    (cpurst),
        .start  (sweep_start),
        .enable (sweep_en),
        .addr   (sweep_addr),
        .last   (sweep_last),
        .busy   (flush_busy),
        .done   (init_done)
    );

    // Next state, arbitration and SRAM pin drive
    always_comb begin
        state_d     = state_q;
        sweep_start = 1'b0;
        sweep_en    = 1'b0;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        sram_a      = '0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_d      = '0;
`ifdef PA_LSU_SPSRAM_CTRL_RD_BYPASS_EN
        byp         = 1'b0;
`endif
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                sweep_en  = 1'b1;
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = sweep_addr;
                sram_d    = INIT_VAL;
                if (sweep_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    sweep_start = 1'b1;
                end else if (wr_vld && !(rd_vld && starve_hit)) begin
                    wr_ready  = 1'b1;
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = ~wr_bmask;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
`ifdef PA_LSU_SPSRAM_CTRL_RD_BYPASS_EN
                    // full-mask writes to the read address forward their data
                    if (rd_vld && (rd_addr == wr_addr) && (&wr_bmask)) begin
                        rd_ready = 1'b1;
                        byp      = 1'b1;
                    end
`endif
                end else if (rd_vld) begin
                    rd_ready = 1'b1;
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q      <= ST_INIT;
            rd_rdata_vld <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            state_q      <= state_d;
            rd_rdata_vld <= rd_ready;
            if (!rd_vld || rd_ready) begin
                starve_cnt <= '0;
            end else if (wr_ready && !starve_hit) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

`ifdef PA_LSU_SPSRAM_CTRL_RD_BYPASS_EN
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q <= byp;
            if (byp) begin
                byp_data_q <= wr_data;
            end
        end
    end

    assign rd_rdata = byp_q ? byp_data_q : sram_q;
`else
    assign rd_rdata = sram_q;
`endif

endmodule
